// File: rtl/cartridge_pkg.sv
// ============================================================================
// Module : cartridge_pkg
// Brief  : Shared types and constants for the Game Boy cartridge bus responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cartridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SETTLE     = 4'd1,
    ST_RD_REQ     = 4'd2,
    ST_RD_WAIT    = 4'd3,
    ST_RD_DIR     = 4'd4,
    ST_DRIVE      = 4'd5,
    ST_RD_RELEASE = 4'd6,
    ST_DRAIN      = 4'd7,
    ST_WR_COLLECT = 4'd8,
    ST_WR_REQ     = 4'd9
  } state_t;

  // ROM lives wherever A15 is clear; external RAM is the A000-BFFF window.
  localparam logic [15:0] c_ROM_MASK = 16'h8000;
  localparam logic [2:0]  c_RAM_BASE = 3'b101;

  localparam logic        c_NRD_IDLE = 1'b1;
  localparam logic        c_NWR_IDLE = 1'b1;
  localparam logic        c_NCS_IDLE = 1'b1;
  localparam logic [15:0] c_A_IDLE   = 16'h0000;
  localparam logic [7:0]  c_D_IDLE   = 8'h00;

  localparam int          c_BUS_W    = 27;
  localparam logic [c_BUS_W-1:0] c_BUS_IDLE =
    {c_A_IDLE, c_D_IDLE, c_NRD_IDLE, c_NWR_IDLE, c_NCS_IDLE};

  function automatic logic is_hit(input logic [15:0] a, input logic ncs);
    return ((a & c_ROM_MASK) == 16'h0000) || ((a[15:13] == c_RAM_BASE) && !ncs);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cartridge_input_sync.sv
// ============================================================================
// Module : cartridge_input_sync
// Brief  : Multi-stage synchroniser for the asynchronous cartridge bus inputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cartridge_input_sync #(
  parameter int               WIDTH       = 27,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= RESET_VALUE;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cartridge_bus_responder.sv
// ============================================================================
// Module : cartridge_bus_responder
// Brief  : Acts as a Game Boy cartridge, forwarding bus accesses to a backend.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cartridge_bus_responder
  import cartridge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cart_a,
  input  logic [7:0]  cart_d_in,
  input  logic        cart_nrd,
  input  logic        cart_nwr,
  input  logic        cart_ncs,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  output logic        cart_dir_d,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [15:0] mem_req_addr,
  output logic [7:0]  mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [7:0]  mem_rsp_rdata,
  output logic        busy,
  output logic [15:0] miss_count
);

  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [c_BUS_W-1:0] w_bus_s;
  logic [15:0]        w_a_s;
  logic [7:0]         w_d_s;
  logic               w_nrd_s;
  logic               w_nwr_s;
  logic               w_ncs_s;

  cartridge_input_sync #(
    .WIDTH       (c_BUS_W),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (c_BUS_IDLE)
  ) u_sync (
    .clk    (clock),
    .rst    (reset),
    .i_data ({cart_a, cart_d_in, cart_nrd, cart_nwr, cart_ncs}),
    .o_data (w_bus_s)
  );

  assign {w_a_s, w_d_s, w_nrd_s, w_nwr_s, w_ncs_s} = w_bus_s;

  state_t      r_state;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [3:0]  r_settle;
  logic        r_nwr_d;
  logic        r_gone;
  logic [7:0]  r_d_out;
  logic        r_oe;
  logic        r_dir;
  logic        r_valid;
  logic        r_write;
  logic [15:0] r_req_addr;
  logic [7:0]  r_req_wdata;
  logic [15:0] r_miss;

  logic w_hit;
  logic w_nwr_fall;
  logic w_abandon;

  assign w_hit      = is_hit(w_a_s, w_ncs_s);
  assign w_nwr_fall = r_nwr_d && !w_nwr_s;
  // The console has moved on from the read we latched.
  assign w_abandon  = (w_a_s != r_addr) || w_nrd_s || !w_nwr_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
      r_settle    <= 4'd0;
      r_nwr_d     <= c_NWR_IDLE;
      r_gone      <= 1'b0;
      r_d_out     <= 8'h00;
      r_oe        <= 1'b0;
      r_dir       <= 1'b0;
      r_valid     <= 1'b0;
      r_write     <= 1'b0;
      r_req_addr  <= 16'h0000;
      r_req_wdata <= 8'h00;
      r_miss      <= 16'h0000;
    end else begin
      r_nwr_d <= w_nwr_s;
      case (r_state)
        ST_IDLE: begin
          if (w_hit && w_nwr_fall) begin
            r_addr  <= w_a_s;
            r_wdata <= w_d_s;
            r_state <= ST_WR_COLLECT;
          end else if (!w_nrd_s && w_nwr_s && w_hit) begin
            r_addr   <= w_a_s;
            r_settle <= 4'd0;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_nrd_s) begin
            r_state <= ST_IDLE;
          end else if (w_a_s != r_addr) begin
            if (w_hit) begin
              r_addr   <= w_a_s;
              r_settle <= 4'd0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (r_settle == c_SETTLE_LAST) begin
            r_valid    <= 1'b1;
            r_write    <= 1'b0;
            r_req_addr <= r_addr;
            r_gone     <= 1'b0;
            r_state    <= ST_RD_REQ;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        ST_RD_REQ: begin
          if (mem_req_ready) begin
            r_valid <= 1'b0;
            if (r_gone || w_abandon) begin
              r_miss  <= sat_inc16(r_miss);
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_RD_WAIT;
            end
          end else if (w_abandon) begin
            r_gone <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (w_abandon) begin
            r_miss  <= sat_inc16(r_miss);
            // A response arriving in the same cycle is already consumed here.
            r_state <= mem_rsp_valid ? ST_IDLE : ST_DRAIN;
          end else if (mem_rsp_valid) begin
            r_d_out <= mem_rsp_rdata;
            r_dir   <= 1'b1;
            r_state <= ST_RD_DIR;
          end
        end
        ST_RD_DIR: begin
          if (w_abandon) begin
            r_miss  <= sat_inc16(r_miss);
            r_state <= ST_RD_RELEASE;
          end else begin
            r_oe    <= 1'b1;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (w_abandon) begin
            r_oe    <= 1'b0;
            r_state <= ST_RD_RELEASE;
          end
        end
        ST_RD_RELEASE: begin
          r_dir   <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (mem_rsp_valid) r_state <= ST_IDLE;
        end
        ST_WR_COLLECT: begin
          if (!w_nwr_s) begin
            r_wdata <= w_d_s;
          end else begin
            r_valid     <= 1'b1;
            r_write     <= 1'b1;
            r_req_addr  <= r_addr;
            r_req_wdata <= r_wdata;
            r_state     <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (mem_req_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cart_d_out    = r_d_out;
  assign cart_d_oe     = r_oe;
  assign cart_dir_d    = r_dir;
  assign mem_req_valid = r_valid;
  assign mem_req_write = r_write;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_wdata = r_req_wdata;
  assign busy          = (r_state != ST_IDLE);
  assign miss_count    = r_miss;

endmodule

`default_nettype wire
